memcopy_sequencer: RTL and testbench
====================================

# memcopy_sequencer

Multi-cycle controller that executes the `memcopy` instruction against the single-ported data memory, one word per read/write pair. It sits between the datapath's load/store path and `datamemory`, and owns the memory port while a copy is in progress. It stalls the PC until the copy completes and otherwise passes CPU loads and stores through unchanged.

## Interface
Parameters:
- `DM_ADDRESS`, 9: data-memory address width.
- `DATA_W`, 32: data word width.
- `copy_w`, 7: width of the copy length field, in words.

Ports:
- `clk`  in  1  global clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-low; the block is in reset when `reset == 0` at a rising edge.
- `start`  in  1  copy request from decode, held while the `memcopy` instruction is at PC.
- `src_addr`  in  DM_ADDRESS  first source word address (`Instr[15:7]`).
- `dst_addr`  in  DM_ADDRESS  first destination word address (`Instr[24:16]`).
- `length`  in  copy_w  number of words to copy (`Instr[31:25]`).
- `cpu_mem_read`, `cpu_mem_write`  in  1  CPU load/store enables.
- `cpu_addr`  in  DM_ADDRESS  CPU data address.
- `cpu_wdata`  in  DATA_W  CPU store data.
- `mem_rdata`  in  DATA_W  data-memory read data, combinational from `mem_addr`.
- `mem_read`, `mem_write`  out  1  data-memory enables.
- `mem_addr`  out  DM_ADDRESS  data-memory address.
- `mem_wdata`  out  DATA_W  data-memory write data.
- `stall`  out  1  holds the PC register when high.
- `busy`  out  1  high in READ and WRITE.
- `done`  out  1  one-cycle completion pulse.

## Operation
- States are IDLE, READ, WRITE, DONE.
- **IDLE**
  - `mem_*` = `cpu_*` (pass-through).
  - `stall` = `start` (combinational).
  - On `start`, latch `src_addr`, `dst_addr` and `length`.
  - Next state is READ if `length != 0`, otherwise DONE.
- **READ**
  - Drive `mem_read=1` and `mem_addr=src_ptr`.
  - Capture `mem_rdata` into `data_q`.
  - Next state is WRITE.
- **WRITE**
  - Drive `mem_write=1`, `mem_addr=dst_ptr` and `mem_wdata=data_q`.
  - Step both pointers and decrement `remaining`.
  - Next state is DONE if `remaining == 1`, otherwise READ.
- **DONE**
  - `done=1` and `stall=0`, so the PC advances past `memcopy`.
  - `mem_*` pass through from the CPU.
  - `start` is ignored in this state.
  - Next state is IDLE.
- While in READ or WRITE:
  - CPU requests are ignored; the CPU is stalled, so none are lost.
  - `stall=1` and `busy=1`.
- Pointer arithmetic:
  - Step is ±1, modulo 2^DM_ADDRESS.
  - Wrap from 511 to 0 (or 0 to 511 when descending) is legal and silent.
- `length` is unsigned; the maximum is 127 words.
- Reset (`reset == 0`), including mid-copy:
  - The next state is IDLE.
  - `mem_read`, `mem_write`, `stall`, `busy` and `done` are forced to 0 during the reset cycle.
  - `data_q`, the pointers and `remaining` clear to 0.
  - Words already written stay written; no further writes occur.

## Timing
- `start` is sampled in cycle 0 (IDLE).
- Word k is read in cycle 1+2k and written in cycle 2+2k.
- DONE occurs in cycle 2L+1. `stall` is high for cycles 0..2L, i.e. 2L+1 cycles.
- For `length == 0`, `stall` is high in cycle 0 only and DONE occurs in cycle 1. No memory access takes place.
- Reset values of the outputs:
  - `mem_read`, `mem_write`, `stall`, `busy`, `done` = 0.
  - `mem_addr` and `mem_wdata` follow the CPU inputs once `reset` is released.

## Configuration
- Macro: `MEMCOPY_OVERLAP_EN`.
- When defined, overlapping copies use memmove semantics:
  - Overlap is `dst > src` and `dst < src + length`, evaluated at `start` with DM_ADDRESS+1-bit unwrapped arithmetic.
  - On overlap, copy descending: pointers start at `src+length-1` and `dst+length-1` and step −1.
  - Without overlap, copy ascending.
- When not defined, copies always ascend with step +1. Overlapping forward copies replicate the leading words; this is the intended behaviour.

## Structure
- `memcopy_pkg` holds:
  - the `memcopy_state_t` enum (IDLE/READ/WRITE/DONE);
  - the `DM_ADDRESS`, `DATA_W` and `copy_w` default constants.
- Sub-module `memcopy_addr_gen` contains the source/destination pointer registers, the `remaining` counter and the direction flag. Its controls are `load`, `step`, `last`.

## Test plan
- Preload mem[10..13] = A,B,C,D, then `start` with src=10, dst=40, len=4. Required: mem[40..43] = A,B,C,D; `stall` high for 9 cycles; `done` pulses in cycle 9.
- `start` with len=0. Required: `stall` high 1 cycle, `done` in cycle 1, no `mem_write` pulse.
- src=510, dst=100, len=4. Required: source words come from 510, 511, 0, 1; destinations are 100..103.
- Preload mem[20..23] = 1,2,3,4, then src=20, dst=22, len=4.
  - With `MEMCOPY_OVERLAP_EN`: mem[22..25] = 1,2,3,4.
  - Without it: mem[22..25] = 1,2,1,2.
- Assert `reset=0` in cycle 4 of a len=8 copy. Required: IDLE next cycle; only words 0 and 1 written; `stall`/`busy`/`done` = 0.
- CPU store (addr 7, data 0x55) in IDLE, then a copy, then a CPU load of addr 7. Required: pass-through write/read returns 0x55; no CPU access occurs during READ/WRITE.

Source files
------------

// File: rtl/memcopy_pkg.sv
// memcopy_pkg: shared state encoding and default widths for the memcopy sequencer.
package memcopy_pkg;

  localparam int MC_DM_ADDRESS = 9;
  localparam int MC_DATA_W     = 32;
  localparam int MC_COPY_W     = 7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } memcopy_state_t;

endpackage

// File: rtl/memcopy_addr_gen.sv
// memcopy_addr_gen: source/destination pointers, remaining-word counter and
// copy direction. With MEMCOPY_OVERLAP_EN defined, a copy whose destination
// lands inside its own source window runs descending (memmove semantics);
// otherwise every copy ascends.
module memcopy_addr_gen #(
  parameter int DM_ADDRESS = 9,
  parameter int copy_w     = 7
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load_i,
  input  logic                  step_i,
  input  logic [DM_ADDRESS-1:0] src_addr_i,
  input  logic [DM_ADDRESS-1:0] dst_addr_i,
  input  logic [copy_w-1:0]     length_i,
  output logic [DM_ADDRESS-1:0] src_ptr_o,
  output logic [DM_ADDRESS-1:0] dst_ptr_o,
  output logic [copy_w-1:0]     remaining_o,
  output logic                  last_o
);

  logic [DM_ADDRESS-1:0] src_q, src_d, dst_q, dst_d;
  logic [DM_ADDRESS-1:0] src_start, dst_start;
  logic [copy_w-1:0]     rem_q, rem_d;
  logic                  dir_q, dir_d;   // 1 = descending
  logic                  overlap;

`ifdef MEMCOPY_OVERLAP_EN
  // Overlap test uses one extra bit so src+length does not wrap.
  logic [DM_ADDRESS:0]   src_ext, dst_ext, end_ext;
  logic [DM_ADDRESS-1:0] len_m1;
  assign src_ext   = {1'b0, src_addr_i};
  assign dst_ext   = {1'b0, dst_addr_i};
  assign end_ext   = src_ext + (DM_ADDRESS+1)'(length_i);
  assign overlap   = (dst_ext > src_ext) && (dst_ext < end_ext);
  assign len_m1    = DM_ADDRESS'(length_i) - DM_ADDRESS'(1);
  assign src_start = overlap ? src_addr_i + len_m1 : src_addr_i;
  assign dst_start = overlap ? dst_addr_i + len_m1 : dst_addr_i;
`else
  assign overlap   = 1'b0;
  assign src_start = src_addr_i;
  assign dst_start = dst_addr_i;
`endif

  // Load on start, otherwise step both pointers (mod 2^DM_ADDRESS) per written word.
  always_comb begin
    src_d = src_q;
    dst_d = dst_q;
    rem_d = rem_q;
    dir_d = dir_q;
    if (load_i) begin
      src_d = src_start;
      dst_d = dst_start;
      rem_d = length_i;
      dir_d = overlap;
    end else if (step_i) begin
      src_d = dir_q ? src_q - DM_ADDRESS'(1) : src_q + DM_ADDRESS'(1);
      dst_d = dir_q ? dst_q - DM_ADDRESS'(1) : dst_q + DM_ADDRESS'(1);
      rem_d = rem_q - copy_w'(1);
    end
  end

  // Pointer/counter registers, cleared by synchronous reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      src_q <= '0;
      dst_q <= '0;
      rem_q <= '0;
      dir_q <= 1'b0;
    end else begin
      src_q <= src_d;
      dst_q <= dst_d;
      rem_q <= rem_d;
      dir_q <= dir_d;
    end
  end

  assign src_ptr_o   = src_q;
  assign dst_ptr_o   = dst_q;
  assign remaining_o = rem_q;
  assign last_o      = (rem_q == copy_w'(1));

endmodule

// File: rtl/memcopy_sequencer.sv
// memcopy_sequencer: owns the data-memory port while a memcopy runs, one
// read/write pair per word, stalling the PC until DONE. In IDLE and DONE the
// CPU load/store path passes straight through. Optional macro
// MEMCOPY_OVERLAP_EN selects memmove-style descending copies on overlap.
module memcopy_sequencer
  import memcopy_pkg::*;
#(
  parameter int DM_ADDRESS = MC_DM_ADDRESS,
  parameter int DATA_W     = MC_DATA_W,
  parameter int copy_w     = MC_COPY_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DM_ADDRESS-1:0] src_addr,
  input  logic [DM_ADDRESS-1:0] dst_addr,
  input  logic [copy_w-1:0]     length,
  input  logic                  cpu_mem_read,
  input  logic                  cpu_mem_write,
  input  logic [DM_ADDRESS-1:0] cpu_addr,
  input  logic [DATA_W-1:0]     cpu_wdata,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [DM_ADDRESS-1:0] mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic                  stall,
  output logic                  busy,
  output logic                  done
);

  memcopy_state_t        state_q, state_d;
  logic [DATA_W-1:0]     data_q, data_d;
  logic                  load, step, last;
  logic [DM_ADDRESS-1:0] src_ptr, dst_ptr;
  logic [copy_w-1:0]     remaining;

  memcopy_addr_gen #(
    .DM_ADDRESS(DM_ADDRESS),
    .copy_w    (copy_w)
  ) u_addr_gen (
    .clk        (clk),
    .reset      (reset),
    .load_i     (load),
    .step_i     (step),
    .src_addr_i (src_addr),
    .dst_addr_i (dst_addr),
    .length_i   (length),
    .src_ptr_o  (src_ptr),
    .dst_ptr_o  (dst_ptr),
    .remaining_o(remaining),
    .last_o     (last)
  );

  // Next-state and memory-port mux; reset overrides everything last.
  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    mem_read  = cpu_mem_read;
    mem_write = cpu_mem_write;
    mem_addr  = cpu_addr;
    mem_wdata = cpu_wdata;
    stall     = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    load      = 1'b0;
    step      = 1'b0;
    case (state_q)
      IDLE: begin
        stall = start;
        if (start) begin
          load    = 1'b1;
          state_d = (length != '0) ? READ : DONE;
        end
      end
      READ: begin
        mem_read  = 1'b1;
        mem_write = 1'b0;
        mem_addr  = src_ptr;
        mem_wdata = data_q;
        stall     = 1'b1;
        busy      = 1'b1;
        data_d    = mem_rdata;
        state_d   = WRITE;
      end
      WRITE: begin
        mem_read  = 1'b0;
        mem_write = 1'b1;
        mem_addr  = dst_ptr;
        mem_wdata = data_q;
        stall     = 1'b1;
        busy      = 1'b1;
        step      = 1'b1;
        // remaining still holds the pre-decrement count here
        state_d   = last ? DONE : READ;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (!reset) begin
      state_d   = IDLE;
      data_d    = '0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      stall     = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      load      = 1'b0;
      step      = 1'b0;
    end
  end

  // State and read-data registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: tb/tb_memcopy_sequencer.sv
// tb_memcopy_sequencer: scoreboard bench with a behavioural data memory.
// Expected copy reads/writes are queued when a copy is launched and popped
// as the sequencer issues them. Honours MEMCOPY_OVERLAP_EN.
module tb_memcopy_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [8:0]  src_addr, dst_addr;
  logic [6:0]  length;
  logic        cpu_mem_read, cpu_mem_write;
  logic [8:0]  cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] mem_rdata;
  logic        mem_read, mem_write;
  logic [8:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        stall, busy, done;

  always #5 clk = ~clk;

  memcopy_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .src_addr     (src_addr),
    .dst_addr     (dst_addr),
    .length       (length),
    .cpu_mem_read (cpu_mem_read),
    .cpu_mem_write(cpu_mem_write),
    .cpu_addr     (cpu_addr),
    .cpu_wdata    (cpu_wdata),
    .mem_rdata    (mem_rdata),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .stall        (stall),
    .busy         (busy),
    .done         (done)
  );

  // behavioural memory with a bench-side preload port
  logic [31:0] mem [512];
  logic [31:0] mdl [512];
  logic        pl_we = 1'b0;
  logic [8:0]  pl_a  = '0;
  logic [31:0] pl_d  = '0;
  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) begin
    if (mem_write) mem[mem_addr] <= mem_wdata;
    if (pl_we)     mem[pl_a]     <= pl_d;
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  logic [8:0]  rq[$];   // expected copy read addresses
  logic [40:0] wq[$];   // expected copy writes {addr, data}

  // scoreboard: copy traffic only appears while busy
  always @(negedge clk) begin
    if (busy && mem_read) begin
      chk("rd_q_nonempty", 32'(rq.size() != 0), 1);
      if (rq.size() != 0) chk("rd_addr", 32'(mem_addr), 32'(rq.pop_front()));
    end
    if (busy && mem_write) begin
      chk("wr_q_nonempty", 32'(wq.size() != 0), 1);
      if (wq.size() != 0) begin
        logic [40:0] e;
        e = wq.pop_front();
        chk("wr_addr", 32'(mem_addr), 32'(e[40:32]));
        chk("wr_data", mem_wdata, e[31:0]);
      end
    end
  end

  task automatic preload(input logic [8:0] a, input logic [31:0] d);
    @(negedge clk);
    pl_we = 1'b1; pl_a = a; pl_d = d;
    mdl[a] = d;
    @(negedge clk);
    pl_we = 1'b0;
  endtask

  // Queue the expected traffic for the first n words of a copy.
  task automatic expect_copy(input logic [8:0] s, input logic [8:0] d,
                             input logic [6:0] l, input int n);
    bit desc = 1'b0;
`ifdef MEMCOPY_OVERLAP_EN
    desc = ({1'b0, d} > {1'b0, s}) && ({1'b0, d} < ({1'b0, s} + 10'(l)));
`endif
    for (int i = 0; i < n; i++) begin
      logic [8:0] sa, da;
      if (desc) begin
        sa = s + 9'(l) - 9'd1 - 9'(i);
        da = d + 9'(l) - 9'd1 - 9'(i);
      end else begin
        sa = s + 9'(i);
        da = d + 9'(i);
      end
      rq.push_back(sa);
      wq.push_back({da, mdl[sa]});
      mdl[da] = mdl[sa];
    end
  endtask

  task automatic run_copy(input string tag, input logic [8:0] s, input logic [8:0] d,
                          input logic [6:0] l, input bit junk);
    int stl = 0, nwr = 0, dcyc = -1;
    expect_copy(s, d, l, int'(l));
    @(negedge clk);
    start = 1'b1; src_addr = s; dst_addr = d; length = l;
    for (int c = 0; c < 400; c++) begin
      // CPU traffic during READ/WRITE must be ignored
      cpu_mem_write = junk && (c >= 1) && (c <= 2 * int'(l));
      cpu_addr      = 9'd7;
      cpu_wdata     = 32'hAA;
      #1;
      stl += int'(stall);
      nwr += int'(mem_write);
      if (done) begin
        dcyc = c;
        break;
      end
      @(negedge clk);
    end
    start = 1'b0;
    cpu_mem_write = 1'b0;
    chk({tag, "_done_cyc"}, 32'(dcyc), 32'(2 * int'(l) + 1));
    chk({tag, "_stall_cyc"}, 32'(stl), 32'(2 * int'(l) + 1));
    chk({tag, "_nwrites"}, 32'(nwr), 32'(l));
    repeat (2) @(negedge clk);
    chk({tag, "_rq_left"}, 32'(rq.size()), 0);
    chk({tag, "_wq_left"}, 32'(wq.size()), 0);
  endtask

  initial begin
    for (int i = 0; i < 512; i++) begin
      mem[i] = 32'h0;
      mdl[i] = 32'h0;
    end
    reset = 1'b0; start = 1'b1; src_addr = '0; dst_addr = '0; length = 7'd3;
    cpu_mem_read = 1'b1; cpu_mem_write = 1'b1; cpu_addr = 9'd3; cpu_wdata = 32'h99;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_mem_read", 32'(mem_read), 0);
    chk("rst_mem_write", 32'(mem_write), 0);
    chk("rst_stall", 32'(stall), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    @(negedge clk);
    reset = 1'b1; start = 1'b0; cpu_mem_read = 1'b0; cpu_mem_write = 1'b0;
    cpu_addr = 9'd5; cpu_wdata = 32'h1234;
    #1;
    chk("pass_addr", 32'(mem_addr), 32'd5);
    chk("pass_wdata", mem_wdata, 32'h1234);
    chk("idle_stall", 32'(stall), 0);

    // basic 4-word copy
    preload(9'd10, 32'hA); preload(9'd11, 32'hB);
    preload(9'd12, 32'hC); preload(9'd13, 32'hD);
    run_copy("basic", 9'd10, 9'd40, 7'd4, 1'b0);
    chk("basic_m40", mem[40], 32'hA);
    chk("basic_m41", mem[41], 32'hB);
    chk("basic_m42", mem[42], 32'hC);
    chk("basic_m43", mem[43], 32'hD);

    // zero length
    run_copy("len0", 9'd10, 9'd80, 7'd0, 1'b0);

    // source wraps 511 -> 0
    preload(9'd510, 32'h510); preload(9'd511, 32'h511);
    preload(9'd0, 32'h1000);  preload(9'd1, 32'h1001);
    run_copy("wrap", 9'd510, 9'd100, 7'd4, 1'b0);
    chk("wrap_m100", mem[100], 32'h510);
    chk("wrap_m103", mem[103], 32'h1001);

    // overlapping forward copy
    preload(9'd20, 32'd1); preload(9'd21, 32'd2);
    preload(9'd22, 32'd3); preload(9'd23, 32'd4);
    run_copy("ovl", 9'd20, 9'd22, 7'd4, 1'b0);
    chk("ovl_m22", mem[22], 32'd1);
    chk("ovl_m23", mem[23], 32'd2);
`ifdef MEMCOPY_OVERLAP_EN
    chk("ovl_m24", mem[24], 32'd3);
    chk("ovl_m25", mem[25], 32'd4);
`else
    chk("ovl_m24", mem[24], 32'd1);
    chk("ovl_m25", mem[25], 32'd2);
`endif

    // reset mid-copy: words 0 and 1 land, the rest never do
    for (int i = 0; i < 8; i++) begin
      preload(9'(60 + i), 32'h600 + 32'(i));
      preload(9'(200 + i), 32'hDEAD);
    end
    expect_copy(9'd60, 9'd200, 7'd8, 2);
    @(negedge clk);
    start = 1'b1; src_addr = 9'd60; dst_addr = 9'd200; length = 7'd8;
    repeat (4) @(negedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0; start = 1'b0;
    #1;
    chk("midrst_stall", 32'(stall), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_done", 32'(done), 0);
    chk("midrst_mem_write", 32'(mem_write), 0);
    chk("midrst_mem_read", 32'(mem_read), 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("post_rst_busy", 32'(busy), 0);
    start = 1'b1; length = 7'd0;
    #1;
    chk("post_rst_idle_stall", 32'(stall), 1);
    start = 1'b0;
    repeat (20) @(negedge clk);
    chk("midrst_m200", mem[200], 32'h600);
    chk("midrst_m201", mem[201], 32'h601);
    chk("midrst_m202", mem[202], 32'hDEAD);
    chk("midrst_m207", mem[207], 32'hDEAD);
    chk("midrst_rq_left", 32'(rq.size()), 0);
    chk("midrst_wq_left", 32'(wq.size()), 0);

    // CPU store, copy with CPU noise, CPU load
    @(negedge clk);
    cpu_mem_write = 1'b1; cpu_addr = 9'd7; cpu_wdata = 32'h55;
    mdl[7] = 32'h55;
    @(negedge clk);
    cpu_mem_write = 1'b0;
    preload(9'd30, 32'h30); preload(9'd31, 32'h31); preload(9'd32, 32'h32);
    run_copy("cpu", 9'd30, 9'd300, 7'd3, 1'b1);
    chk("cpu_m302", mem[302], 32'h32);
    @(negedge clk);
    cpu_mem_read = 1'b1; cpu_addr = 9'd7;
    #1;
    chk("cpu_ld_read", 32'(mem_read), 1);
    chk("cpu_ld_data", mem_rdata, 32'h55);
    @(negedge clk);
    cpu_mem_read = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
